fifo_rd_arbiter: RTL

- Round-robin read arbiter for the 8 read channels of the shared SyncFIFO.
- Generates the registered one-hot `select` consumed by the FIFO read-control mux, which routes the chosen channel's rd_en/rd_only to the FIFO core.
- Grants are burst-based: the owner keeps the FIFO until it drops its request, hits MAX_BURST reads, or the FIFO runs empty.
- `select` never changes while a grant is active, so the downstream mux is glitch-free per burst.

---
 rtl/fifo_rd_arbiter_if.sv | 24 ++
 rtl/fifo_rd_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter_if.sv
// rtl/fifo_rd_arbiter_if.sv - request/grant bundle between the SyncFIFO read channels and the read arbiter
interface fifo_rd_arbiter_if #(
   parameter int BURST_W = 8
) ();
   logic [7:0]         rd_req;
   logic               rd_en;
   logic               empty;
   logic [7:0]         select;
   logic               grant_valid;
   logic [2:0]         grant_idx;
   logic [BURST_W-1:0] burst_cnt;

   // arbiter side
   modport master (
      input  rd_req, rd_en, empty,
      output select, grant_valid, grant_idx, burst_cnt
   );

   // requester / read-mux side
   modport slave (
      output rd_req, rd_en, empty,
      input  select, grant_valid, grant_idx, burst_cnt
   );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - burst round-robin read arbiter for the 8 SyncFIFO read channels (optional FIFO_RD_ARB_PRIO_EN: channel 0 high priority with preemption)
module fifo_rd_arbiter #(
   parameter int MAX_BURST        = 16,
   parameter int BURST_W          = 8,
   parameter bit RELEASE_ON_EMPTY = 1'b1
) (
   input logic                 clk,
   input logic                 rst_n,
   fifo_rd_arbiter_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [2:0]         ptr, ptr_n;
   logic [7:0]         select_q, select_n;
   logic [2:0]         grant_idx_q, grant_idx_n;
   logic               grant_valid_q, grant_valid_n;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_n;

   logic [2:0]         win;
   logic               found;
   logic [2:0]         cand;
   logic               read_cnt;
   logic               last_read;
   logic               preempt;
   logic               release_now;

   // circular search for the next requester, starting just after the last winner
   always_comb begin
      win   = 3'd0;
      found = 1'b0;
      cand  = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         cand = ptr + 3'(k);
         if (!found && bus.rd_req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
`ifdef FIFO_RD_ARB_PRIO_EN
      if (bus.rd_req[0]) begin
         win   = 3'd0;
         found = 1'b1;
      end
`endif
   end

   // release conditions for the current owner
   always_comb begin
      read_cnt    = bus.rd_en && !bus.empty;
      last_read   = read_cnt && (burst_cnt_q == BURST_W'(MAX_BURST - 1));
`ifdef FIFO_RD_ARB_PRIO_EN
      preempt     = bus.rd_req[0] && (grant_idx_q != 3'd0);
`else
      preempt     = 1'b0;
`endif
      release_now = !bus.rd_req[grant_idx_q] || last_read ||
                    (RELEASE_ON_EMPTY && bus.empty) || preempt;
   end

   // next-state and next-output logic
   always_comb begin
      state_n       = state;
      ptr_n         = ptr;
      select_n      = select_q;
      grant_idx_n   = grant_idx_q;
      grant_valid_n = grant_valid_q;
      burst_cnt_n   = burst_cnt_q;
      case (state)
         IDLE, GAP: begin
            if (found) begin
               state_n       = GRANT;
               select_n      = 8'b1 << win;
               grant_idx_n   = win;
               grant_valid_n = 1'b1;
               burst_cnt_n   = '0;
            end else begin
               state_n       = IDLE;
               grant_valid_n = 1'b0;
            end
         end
         GRANT: begin
            if (read_cnt) begin
               burst_cnt_n = burst_cnt_q + 1'b1;
            end
            if (release_now) begin
               state_n       = GAP;
               grant_valid_n = 1'b0;
               // a preempted owner keeps its round-robin position
               if (!preempt) begin
                  ptr_n = grant_idx_q;
               end
            end
         end
         default: begin
            state_n       = IDLE;
            grant_valid_n = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= 3'd7;
         select_q      <= 8'b0000_0001;
         grant_idx_q   <= 3'd0;
         grant_valid_q <= 1'b0;
         burst_cnt_q   <= '0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         select_q      <= select_n;
         grant_idx_q   <= grant_idx_n;
         grant_valid_q <= grant_valid_n;
         burst_cnt_q   <= burst_cnt_n;
      end
   end

   assign bus.select      = select_q;
   assign bus.grant_idx   = grant_idx_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.burst_cnt   = burst_cnt_q;

endmodule
